serial_parity_rx: RTL and testbench

Serial frame receiver with even-parity check. It recovers 8-bit words from a single-wire asynchronous line: idle-high, start bit, LSB-first data, even parity bit, stop bit. The parity bit is recomputed with a running XOR of the data bits and compared against the received parity bit. The block sits at the receive end of the team's serial link, opposite the XOR-based parity transmitter, and hands each word to downstream logic with a one-cycle valid pulse and error flags.

---
 rtl/serial_parity_rx.sv | 143 ++++++++++++++
 tb/tb_serial_parity_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_rx.sv
// Asynchronous serial receiver: start bit, LSB-first data, even parity, stop bit.
// Delivers each word with a one-cycle valid pulse plus parity and framing flags.
module serial_parity_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 acc;
  logic                 perr;
  logic                 sync1;
  logic                 rxs;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  // Receive FSM; cnt is cleared on every transition and otherwise free-runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      acc        <= 1'b0;
      perr       <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      cnt   <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          cnt   <= '0;
          idx   <= '0;
          shreg <= '0;
          acc   <= 1'b0;
          if (!rxs) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          // Mid-bit recheck rejects short low glitches.
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxs) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            acc   <= acc ^ rxs;
            idx   <= idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            perr  <= acc ^ rxs;
            state <= STOP;
          end
        end
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt        <= '0;
            data       <= shreg;
            parity_err <= perr;
            frame_err  <= ~rxs;
            valid      <= 1'b1;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          // A held-low line must return high before a new start is accepted.
          cnt <= '0;
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: table-driven frames, hand-written corner cases and
// randomized frames checked against an arithmetic parity/framing model.
`timescale 1ns/1ps
module tb_serial_parity_rx;

  localparam int unsigned CPB       = 16;
  localparam int unsigned DB        = 8;
  localparam int unsigned VALID_LAT = 2 + CPB / 2 + (DB + 2) * CPB + 1;
  localparam int unsigned FRAME_CYC = (DB + 3) * CPB;
  localparam int          NV        = 9;

  logic          clk;
  logic          rst;
  logic          rxd;
  logic [DB-1:0] data;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  serial_parity_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    int unsigned   cyc;
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  typedef struct {
    logic [DB-1:0] d;
    logic          p;
    logic          s;
    logic [DB-1:0] exp_d;
    logic          exp_pe;
    logic          exp_fe;
  } vec_t;

  int unsigned   cyc = 0;
  int unsigned   n_pass = 0;
  int unsigned   n_total = 0;
  exp_t          exp_q[$];
  int unsigned   vq[$];
  exp_t          mon_e;
  logic          chk_busy_next = 1'b0;
  logic [DB-1:0] last_d = '0;
  logic          last_pe = 1'b0;
  logic          last_fe = 1'b0;
  vec_t          tbl[NV];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Scoreboard: every valid must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (chk_busy_next) begin
      check("busy_after_valid", {31'd0, busy}, 32'd0);
      chk_busy_next = 1'b0;
    end
    if (valid === 1'b1) begin
      vq.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'd0, valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("valid_cycle", cyc, mon_e.cyc);
        check("data", {24'd0, data}, {24'd0, mon_e.d});
        check("parity_err", {31'd0, parity_err}, {31'd0, mon_e.pe});
        check("frame_err", {31'd0, frame_err}, {31'd0, mon_e.fe});
        check("busy_at_valid", {31'd0, busy}, {31'd0, mon_e.fe});
        last_d  = mon_e.d;
        last_pe = mon_e.pe;
        last_fe = mon_e.fe;
        chk_busy_next = ~mon_e.fe;
      end
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input int unsigned n);
    rxd = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s,
                            input logic [DB-1:0] ed, input logic epe, input logic efe);
    exp_t e;
    e.cyc = cyc + VALID_LAT;
    e.d   = ed;
    e.pe  = epe;
    e.fe  = efe;
    exp_q.push_back(e);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < int'(DB); i++) drive_bit(d[i], CPB);
    drive_bit(p, CPB);
    drive_bit(s, CPB);
  endtask

  task automatic at_cycle(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_data"}, {24'd0, data}, {24'd0, last_d});
    check({tag, "_perr"}, {31'd0, parity_err}, {31'd0, last_pe});
    check({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, last_fe});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   fall;
    int unsigned   rel;
    int unsigned   nv0;
    logic [DB-1:0] rd;
    logic          rp;
    logic          rs;
    logic          mpe;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[6] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
    tbl[7] = '{8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
    tbl[8] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    drive_bit(1'b1, 10);

    // Table-driven frames with an idle gap; outputs must hold afterwards.
    for (int i = 0; i < NV; i++) begin
      send_frame(tbl[i].d, tbl[i].p, tbl[i].s, tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe);
      drive_bit(1'b1, 2 * CPB);
      check_held("tbl_held");
    end

    // Start glitch: three low cycles must be rejected at the mid-bit sample.
    fall = cyc;
    drive_bit(1'b0, 3);
    rxd = 1'b1;
    at_cycle(fall + 3);
    check("glitch_busy_rise", {31'd0, busy}, 32'd1);
    at_cycle(fall + 10);
    check("glitch_busy_hold", {31'd0, busy}, 32'd1);
    at_cycle(fall + 11);
    check("glitch_busy_fall", {31'd0, busy}, 32'd0);
    check_held("glitch_held");
    @(posedge clk);
    #1;
    drive_bit(1'b1, CPB);

    // Framing error followed by a line held low for five bit times.
    send_frame(8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    drive_bit(1'b0, 5 * CPB);
    check("break_busy_low_line", {31'd0, busy}, 32'd1);
    rel = cyc;
    rxd = 1'b1;
    at_cycle(rel + 2);
    check("break_busy_before_rise", {31'd0, busy}, 32'd1);
    at_cycle(rel + 3);
    check("break_busy_drop", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    drive_bit(1'b1, 2 * CPB);
    check("break_pending", exp_q.size(), 32'd0);
    check_held("break_held");

    // Reset during the fourth data bit of 0xFF; the partial frame is discarded.
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, 3 * CPB + CPB / 2);
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_data", {24'd0, data}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_perr", {31'd0, parity_err}, 32'd0);
    check("midrst_ferr", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    last_d  = '0;
    last_pe = 1'b0;
    last_fe = 1'b0;
    drive_bit(1'b1, 2 * CPB);
    check_held("midrst_held");
    send_frame(8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
    drive_bit(1'b1, 2 * CPB);
    check("post_rst_data", {24'd0, data}, 32'h81);

    // Back-to-back frames with no idle time between them.
    nv0 = vq.size();
    send_frame(8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    drive_bit(1'b1, 2 * CPB);
    check("b2b_valid_count", vq.size() - nv0, 32'd3);
    if (vq.size() >= nv0 + 3) begin
      check("b2b_spacing_1", vq[nv0 + 1] - vq[nv0], FRAME_CYC);
      check("b2b_spacing_2", vq[nv0 + 2] - vq[nv0 + 1], FRAME_CYC);
    end

    // Randomized frames: parity flag is set when the ones count is odd.
    for (int i = 0; i < 24; i++) begin
      rd  = DB'($urandom);
      rp  = 1'($urandom);
      rs  = ($urandom_range(0, 3) != 0);
      mpe = ($countones({rd, rp}) % 2) != 0;
      send_frame(rd, rp, rs, rd, mpe, ~rs);
      if (!rs) begin
        drive_bit(1'b0, $urandom_range(0, 2 * CPB));
        drive_bit(1'b1, $urandom_range(2, 30));
      end else begin
        drive_bit(1'b1, $urandom_range(0, 30));
      end
    end
    drive_bit(1'b1, 2 * CPB);
    check("final_pending", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
